// File: rtl/anim_sequencer.sv
// Keyframe animation sequencer: a period counter drives the live frame index
// according to the playback mode, and a consumer-paced point stream walks the
// points of the frame in use, producing the keyframe ROM address.
//
// Ping-pong direction register:
//   state    | meaning
//   DIR_UP   | next ping-pong step increments the frame
//   DIR_DOWN | next ping-pong step decrements the frame
module anim_sequencer #(
    parameter int N_FRAMES = 4,
    parameter int N_POINTS = 48,
    parameter int PERIOD_W = 23,
    parameter int FRAME_W  = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
    parameter int POINT_W  = (N_POINTS > 1) ? $clog2(N_POINTS) : 1,
    parameter int ADDR_W   = (N_FRAMES * N_POINTS > 1) ? $clog2(N_FRAMES * N_POINTS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [1:0]          mode_in,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                pause_in,
    input  logic                restart_in,
    input  logic                next_point_in,
    output logic [FRAME_W-1:0]  frame_live_out,
    output logic [FRAME_W-1:0]  frame_out,
    output logic [POINT_W-1:0]  point_idx_out,
    output logic [ADDR_W-1:0]   rom_addr_out,
    output logic                point_last_out,
    output logic                frame_tick_out,
    output logic                done_out
);

    localparam logic [1:0] MODE_LOOP     = 2'b00;
    localparam logic [1:0] MODE_PINGPONG = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(N_FRAMES - 1);
    localparam logic [POINT_W-1:0] LAST_POINT = POINT_W'(N_POINTS - 1);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period_m1;
    logic [FRAME_W-1:0]  frame_live;
    logic [FRAME_W-1:0]  frame_next;
    logic [FRAME_W-1:0]  frame_use;
    logic [POINT_W-1:0]  point_idx;
    logic [0:0]          dir;
    logic [0:0]          dir_eff;
    logic [0:0]          dir_next;
    logic                done;
    logic                done_next;
    logic                tick;
    logic                counting;
    logic                advance;

    // Advance decision and next frame/direction/done for the current mode.
    always_comb begin
        period_m1  = (period_in == '0) ? '0 : period_in - 1'b1;
        counting   = !pause_in && (mode_in != MODE_HOLD) && !done;
        advance    = counting && (cnt >= period_m1);
        frame_next = frame_live;
        dir_next   = dir;
        done_next  = done;
        // A mode switch can leave the frame at an end with the direction
        // still pointing outward; the ends always force the direction inward.
        dir_eff    = (frame_live == LAST_FRAME) ? DIR_DOWN :
                     (frame_live == '0)         ? DIR_UP   : dir;
        if (advance) begin
            case (mode_in)
                MODE_LOOP: begin
                    frame_next = (frame_live == LAST_FRAME) ? '0 : frame_live + 1'b1;
                end
                MODE_PINGPONG: begin
                    if (N_FRAMES > 1) begin
                        frame_next = (dir_eff == DIR_UP) ? frame_live + 1'b1 : frame_live - 1'b1;
                        dir_next   = (frame_next == LAST_FRAME) ? DIR_DOWN :
                                     (frame_next == '0)         ? DIR_UP   : dir_eff;
                    end
                end
                MODE_ONESHOT: begin
                    if (frame_live != LAST_FRAME) begin
                        frame_next = frame_live + 1'b1;
                    end
                    if (frame_next == LAST_FRAME) begin
                        done_next = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Period counter, live frame, direction, done flag and tick pulse.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt        <= '0;
            frame_live <= '0;
            dir        <= DIR_UP;
            done       <= 1'b0;
            tick       <= 1'b0;
        end else if (restart_in) begin
            cnt        <= '0;
            frame_live <= '0;
            dir        <= DIR_UP;
            done       <= 1'b0;
            tick       <= 1'b0;
        end else begin
            if (advance) begin
                cnt <= '0;
            end else if (counting) begin
                cnt <= cnt + 1'b1;
            end
            frame_live <= frame_next;
            dir        <= dir_next;
            done       <= done_next;
            tick       <= advance;
        end
    end

    // The stream picks up a new frame only on the point wrap; frame_next
    // already equals frame_live when no advance happens this cycle.
    assign frame_use = frame_next;

    // Point index and the frame used by the point stream.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            point_idx <= '0;
            frame_out <= '0;
        end else if (restart_in) begin
            point_idx <= '0;
            frame_out <= '0;
        end else if (next_point_in) begin
            if (point_idx == LAST_POINT) begin
                point_idx <= '0;
                frame_out <= frame_use;
            end else begin
                point_idx <= point_idx + 1'b1;
            end
        end
    end

    assign frame_live_out = frame_live;
    assign point_idx_out  = point_idx;
    assign frame_tick_out = tick;
    assign done_out       = done;
    assign point_last_out = (point_idx == LAST_POINT);
    assign rom_addr_out   = ADDR_W'(frame_out) * ADDR_W'(N_POINTS) + ADDR_W'(point_idx);

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer: a behavioural model predicts the
// outputs after every clock edge, a monitor compares them on the falling edge,
// and directed scenarios check tick timing and frame sequences.
module tb_anim_sequencer;

    localparam int NF  = 4;
    localparam int NP  = 3;
    localparam int PW  = 8;
    localparam int FW  = 2;
    localparam int PTW = 2;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic [PW-1:0] period = 8'd1;
    logic          pause = 1'b0;
    logic          restart = 1'b0;
    logic          next_point = 1'b0;

    logic [FW-1:0]  frame_live_out;
    logic [FW-1:0]  frame_out;
    logic [PTW-1:0] point_idx_out;
    logic [AW-1:0]  rom_addr_out;
    logic           point_last_out;
    logic           frame_tick_out;
    logic           done_out;

    anim_sequencer #(
        .N_FRAMES(NF), .N_POINTS(NP), .PERIOD_W(PW)
    ) dut (
        .clk_in(clk), .rst_in(rst), .mode_in(mode), .period_in(period),
        .pause_in(pause), .restart_in(restart), .next_point_in(next_point),
        .frame_live_out(frame_live_out), .frame_out(frame_out),
        .point_idx_out(point_idx_out), .rom_addr_out(rom_addr_out),
        .point_last_out(point_last_out), .frame_tick_out(frame_tick_out),
        .done_out(done_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW-1:0]  fl;
        logic [FW-1:0]  fo;
        logic [PTW-1:0] pi;
        logic [AW-1:0]  ra;
        logic           pl;
        logic           tk;
        logic           dn;
    } obs_t;

    typedef struct { int tgt; obs_t exp; } sb_t;
    typedef struct { int e; int f; bit d; } tk_t;

    sb_t sbq[$];
    tk_t tq[$];
    int  total = 0;
    int  bad = 0;
    int  edge_cnt = 0;

    // Reference model state
    int m_cnt, m_frame, m_fout, m_pidx;
    bit m_up, m_done, m_tick;

    always @(posedge clk) edge_cnt++;

    // Monitor: pop every prediction whose edge has occurred and compare.
    always @(negedge clk) begin
        obs_t act;
        sb_t  s;
        act = {frame_live_out, frame_out, point_idx_out, rom_addr_out,
               point_last_out, frame_tick_out, done_out};
        while (sbq.size() > 0 && sbq[0].tgt <= edge_cnt) begin
            s = sbq.pop_front();
            total++;
            if (act !== s.exp) begin
                bad++;
                $display("FAIL scoreboard edge=%0d got fl=%0d fo=%0d pi=%0d ra=%0d pl=%0b tk=%0b dn=%0b expected fl=%0d fo=%0d pi=%0d ra=%0d pl=%0b tk=%0b dn=%0b",
                         edge_cnt, act.fl, act.fo, act.pi, act.ra, act.pl, act.tk, act.dn,
                         s.exp.fl, s.exp.fo, s.exp.pi, s.exp.ra, s.exp.pl, s.exp.tk, s.exp.dn);
            end
        end
        if (frame_tick_out === 1'b1) tq.push_back('{edge_cnt, int'(frame_live_out), done_out});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_frame = 0; m_fout = 0; m_pidx = 0;
        m_up = 1'b1; m_done = 1'b0; m_tick = 1'b0;
    endtask

    // One clock of behaviour, from the playback rules.
    task automatic model_step();
        int  pe, nf, span, ph;
        bit  cntg, adv;
        if (rst || restart) begin
            model_reset();
            return;
        end
        pe   = (period == 0) ? 1 : int'(period);
        cntg = !pause && (mode != 2'b11) && !m_done;
        adv  = cntg && (m_cnt >= pe - 1);
        nf   = m_frame;
        if (adv) begin
            case (mode)
                2'b00: nf = (m_frame + 1) % NF;
                2'b01: begin
                    if (NF > 1) begin
                        // Ping-pong as a walk around a ring of 2*(NF-1) phases.
                        span = 2 * (NF - 1);
                        if (m_frame == NF - 1)      ph = NF - 1;
                        else if (m_frame == 0)      ph = 0;
                        else                        ph = m_up ? m_frame : span - m_frame;
                        ph   = (ph + 1) % span;
                        nf   = (ph < NF) ? ph : span - ph;
                        m_up = (ph < NF - 1);
                    end
                end
                2'b10: begin
                    nf = (m_frame + 1 > NF - 1) ? NF - 1 : m_frame + 1;
                    if (nf == NF - 1) m_done = 1'b1;
                end
                default: ;
            endcase
        end
        m_cnt  = adv ? 0 : (cntg ? m_cnt + 1 : m_cnt);
        m_tick = adv;
        if (next_point) begin
            if (m_pidx == NP - 1) begin
                m_pidx = 0;
                m_fout = nf;
            end else begin
                m_pidx++;
            end
        end
        m_frame = nf;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.fl = FW'(m_frame);
        o.fo = FW'(m_fout);
        o.pi = PTW'(m_pidx);
        o.ra = AW'(m_fout * NP + m_pidx);
        o.pl = (m_pidx == NP - 1);
        o.tk = m_tick;
        o.dn = m_done;
        return o;
    endfunction

    // Inputs are set before the call; the prediction for the coming edge is
    // queued, then the task returns just after the following falling edge.
    task automatic cycle();
        model_step();
        sbq.push_back('{edge_cnt + 1, model_obs()});
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_restart(output int r);
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        r = edge_cnt;
        tq.delete();
    endtask

    task automatic run_ticks(input int n, input int budget);
        while (tq.size() < n && budget > 0) begin
            cycle();
            budget--;
        end
        if (tq.size() < n) check("tick_budget", tq.size(), n);
    endtask

    function automatic int out_bits();
        return int'({frame_live_out, frame_out, point_idx_out, rom_addr_out,
                     point_last_out, frame_tick_out, done_out});
    endfunction

    initial begin
        int r;
        int pp_exp[8];
        pp_exp = '{1, 2, 3, 2, 1, 0, 1, 2};
        model_reset();

        // Reset state
        #2;
        check("reset_outputs", out_bits(), 0);
        cycle();
        cycle();
        rst = 1'b0;

        // Loop, P=5
        mode = 2'b00; period = 8'd5;
        do_restart(r);
        run_ticks(5, 40);
        if (tq.size() >= 5) begin
            check("loop_first_tick", tq[0].e - r, 5);
            for (int i = 0; i < 5; i++) check("loop_frame", tq[i].f, (i + 1) % NF);
            for (int i = 1; i < 5; i++) check("loop_spacing", tq[i].e - tq[i-1].e, 5);
        end
        check("loop_frame_out_held", int'(frame_out), 0);
        do_restart(r);
        run_ticks(1, 10);
        next_point = 1'b1;
        repeat (3) cycle();
        next_point = 1'b0;
        check("loop_wrap_frame_out", int'(frame_out), 1);
        check("loop_wrap_point_idx", int'(point_idx_out), 0);

        // Ping-pong, P=2
        mode = 2'b01; period = 8'd2;
        do_restart(r);
        run_ticks(8, 40);
        if (tq.size() >= 8) begin
            for (int i = 0; i < 8; i++) check("pingpong_frame", tq[i].f, pp_exp[i]);
        end
        check("pingpong_done", int'(done_out), 0);

        // One-shot, P=4
        mode = 2'b10; period = 8'd4;
        do_restart(r);
        run_ticks(3, 30);
        if (tq.size() >= 3) begin
            check("oneshot_last_frame", tq[2].f, NF - 1);
            check("oneshot_done_with_tick", int'(tq[2].d), 1);
            check("oneshot_not_done_early", int'(tq[1].d), 0);
        end
        repeat (20) cycle();
        check("oneshot_no_more_ticks", tq.size(), 3);
        do_restart(r);
        check("oneshot_restart_outputs", out_bits(), 0);
        run_ticks(1, 10);
        if (tq.size() >= 1) check("oneshot_resume_latency", tq[0].e - r, 4);

        // Pause, P=6, then period 0
        mode = 2'b00; period = 8'd6;
        do_restart(r);
        repeat (2) cycle();
        pause = 1'b1;
        repeat (10) cycle();
        pause = 1'b0;
        run_ticks(1, 20);
        if (tq.size() >= 1) check("pause_tick_cycle", tq[0].e - r, 16);
        period = 8'd0;
        tq.delete();
        repeat (5) cycle();
        check("period0_ticks", tq.size(), 5);

        // Address stream, P=9
        period = 8'd9;
        do_restart(r);
        run_ticks(2, 30);
        next_point = 1'b1;
        repeat (3) cycle();
        check("addr_6", int'(rom_addr_out), 6);
        check("last_at_6", int'(point_last_out), 0);
        cycle();
        check("addr_7", int'(rom_addr_out), 7);
        check("last_at_7", int'(point_last_out), 0);
        cycle();
        check("addr_8", int'(rom_addr_out), 8);
        check("last_at_8", int'(point_last_out), 1);
        next_point = 1'b0;
        while (edge_cnt < r + 26) cycle();
        next_point = 1'b1;
        cycle();
        next_point = 1'b0;
        check("coincident_tick", int'(frame_tick_out), 1);
        check("coincident_frame_out", int'(frame_out), 3);
        check("coincident_addr", int'(rom_addr_out), 9);

        // Asynchronous reset mid-frame, P=5
        period = 8'd5;
        do_restart(r);
        run_ticks(2, 20);
        repeat (3) cycle();
        check("prereset_frame_live", int'(frame_live_out), 2);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", out_bits(), 0);
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        r = edge_cnt;
        tq.delete();
        run_ticks(1, 20);
        if (tq.size() >= 1) check("post_reset_latency", tq[0].e - r, 5);

        // Randomised run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 5) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 10) period = PW'($urandom_range(0, 7));
            pause      = ($urandom_range(0, 99) < 10);
            restart    = ($urandom_range(0, 99) < 2);
            next_point = ($urandom_range(0, 99) < 40);
            cycle();
        end
        restart = 1'b0; pause = 1'b0; next_point = 1'b0;
        cycle();
        check("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
